pixel_frame_reader: RTL and testbench

PIXEL_FRAME_READER -- requirements
Module: pixel_frame_reader

---
 rtl/dehaze_pkg.sv | 24 ++
 rtl/pixel_frame_reader_if.sv | 36 +++
 rtl/raster_counter.sv | 55 +++++
 rtl/pixel_frame_reader.sv | 155 +++++++++++++++
 tb/tb_pixel_frame_reader.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dehaze_pkg.sv
// Shared constants and types for the dehaze pixel pipeline.
// Contents:
//   PIXEL_W            - width of one packed {R,G,B} pixel
//   DEFAULT_IMG_WIDTH  - default pixels per row
//   DEFAULT_IMG_HEIGHT - default rows per frame
//   reader_state_t     - state encoding of the frame reader FSM
package dehaze_pkg;

  localparam int PIXEL_W            = 24;
  localparam int DEFAULT_IMG_WIDTH  = 512;
  localparam int DEFAULT_IMG_HEIGHT = 512;

  // One pixel is fetched as three byte reads (B, G, R), then captured and
  // presented on the output until the downstream accepts it.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_B,
    ST_FETCH_G,
    ST_FETCH_R,
    ST_CAPTURE,
    ST_OUT
  } reader_state_t;

endpackage

// File: rtl/pixel_frame_reader_if.sv
// Bus bundle between the frame reader, its byte-wide frame memory and the
// downstream pixel consumer.
// Signals:
//   mem_rd_en, mem_addr - read strobe and byte address (reader drives)
//   mem_rdata           - read data, one cycle after mem_rd_en (memory drives)
//   input_pixel         - {R,G,B} pixel, B in [7:0] (reader drives)
//   input_is_valid      - input_pixel holds a pixel (reader drives)
//   pixel_ready         - consumer accepts the pixel (consumer drives)
//   sof, eol, eof       - frame/row position flags, qualified by input_is_valid
// Modports: master = reader side, slave = memory/consumer side.
interface pixel_frame_reader_if #(
  parameter int ADDR_W = 20
);
  import dehaze_pkg::*;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [PIXEL_W-1:0] input_pixel;
  logic              input_is_valid;
  logic              pixel_ready;
  logic              sof;
  logic              eol;
  logic              eof;

  modport master (
    output mem_rd_en, mem_addr, input_pixel, input_is_valid, sof, eol, eof,
    input  mem_rdata, pixel_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, input_pixel, input_is_valid, sof, eol, eof,
    output mem_rdata, pixel_ready
  );

endinterface

// File: rtl/raster_counter.sv
// Row/column position tracker for a raster-scanned frame.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart at row 0, column 0 (new frame)
//   advance   - step to the next pixel position
//   sof       - current position is row 0, column 0
//   eol       - current position is the last column of a row
//   eof       - current position is the last pixel of the frame
module raster_counter
  import dehaze_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int HEIGHT = DEFAULT_IMG_HEIGHT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  output logic sof,
  output logic eol,
  output logic eof
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Column steps every accepted pixel and wraps at the row end, carrying
  // into the row counter; the row wraps after the last row of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (eol) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign sof = (row == '0) && (col == '0);
  assign eol = (col == LAST_COL);
  assign eof = eol && (row == LAST_ROW);

endmodule

// File: rtl/pixel_frame_reader.sv
// Reads a frame of 24-bit BGR pixels from a byte-wide memory (BMP pixel
// data, kept in memory order) and streams them out with a valid/ready
// handshake and sof/eol/eof position flags.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - one-cycle request to begin a frame (ignored while busy)
//   abort      - drop the current frame and return to idle
//   base_addr  - byte address of the first pixel byte
//   bus        - memory read port and pixel output stream (master side)
//   busy       - a frame is in progress
//   frame_done - one-cycle pulse after the last pixel is accepted
module pixel_frame_reader
  import dehaze_pkg::*;
#(
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
  parameter int ADDR_W     = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  pixel_frame_reader_if.master bus,
  output logic              busy,
  output logic              frame_done
);

  reader_state_t      state_q;
  reader_state_t      state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         b_q;
  logic [7:0]         g_q;
  logic [PIXEL_W-1:0] pixel_q;
  logic               valid_q;
  logic               done_q;
  logic               handshake;
  logic               start_frame;
  logic               advance;
  logic               sof_pos;
  logic               eol_pos;
  logic               eof_pos;

  // valid_q is only ever high in ST_OUT, so it alone qualifies the handshake.
  // abort overrides both starting a frame and accepting a pixel.
  assign handshake   = valid_q && bus.pixel_ready;
  assign start_frame = (state_q == ST_IDLE) && start && !abort;
  assign advance     = handshake && !abort;

  raster_counter #(
    .WIDTH  (IMG_WIDTH),
    .HEIGHT (IMG_HEIGHT)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_frame),
    .advance (advance),
    .sof     (sof_pos),
    .eol     (eol_pos),
    .eof     (eof_pos)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the memory read port. The three fetch states issue
  // B, G, R reads back to back; the byte for each read arrives one state
  // later, which is why CAPTURE exists to collect the R byte.
  always_comb begin
    state_d       = state_q;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_frame) state_d = ST_FETCH_B;
      end
      ST_FETCH_B: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = addr_q;
        state_d       = ST_FETCH_G;
      end
      ST_FETCH_G: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = addr_q + ADDR_W'(1);
        state_d       = ST_FETCH_R;
      end
      ST_FETCH_R: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = addr_q + ADDR_W'(2);
        state_d       = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (handshake) state_d = eof_pos ? ST_IDLE : ST_FETCH_B;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Datapath: pixel address, byte capture, output pixel and completion pulse.
  // The output pixel register keeps its value after a handshake so that the
  // consumer sees a stable bus; only valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      b_q     <= '0;
      g_q     <= '0;
      pixel_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (start_frame) begin
        addr_q <= base_addr;
      end else if (advance) begin
        addr_q <= addr_q + ADDR_W'(3);
      end

      if (state_q == ST_FETCH_G) b_q <= bus.mem_rdata;
      if (state_q == ST_FETCH_R) g_q <= bus.mem_rdata;

      if (abort) begin
        valid_q <= 1'b0;
      end else if (state_q == ST_CAPTURE) begin
        pixel_q <= {bus.mem_rdata, g_q, b_q};
        valid_q <= 1'b1;
      end else if (handshake) begin
        valid_q <= 1'b0;
      end

      done_q <= advance && eof_pos;
    end
  end

  // Position flags are meaningful only alongside a valid pixel, which also
  // keeps them low out of reset while the counters sit at row 0, column 0.
  assign bus.input_pixel    = pixel_q;
  assign bus.input_is_valid = valid_q;
  assign bus.sof            = sof_pos && valid_q;
  assign bus.eol            = eol_pos && valid_q;
  assign bus.eof            = eof_pos && valid_q;
  assign busy               = (state_q != ST_IDLE);
  assign frame_done         = done_q;

endmodule

// File: tb/tb_pixel_frame_reader.sv
// Self-checking bench for pixel_frame_reader with a 4x2 frame and a byte
// memory whose byte n reads back as n mod 256.
module tb_pixel_frame_reader;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int AW     = 20;
  localparam int TOTAL  = W * H;

  typedef struct {
    logic [AW-1:0] base;
    int            ready_pct;
    int            stall_pix;
    int            stall_len;
    bit            start_noise;
    logic [23:0]   exp_first;
    logic [23:0]   exp_third;
  } frame_vec_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          frame_done;

  int vec_count;
  int miss_count;

  frame_vec_t vecs[5];

  pixel_frame_reader_if #(.ADDR_W(AW)) bus ();

  pixel_frame_reader #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame memory model: byte n holds n mod 256, returned one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= bus.mem_addr[7:0];
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value.
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference pixel n of a frame: three consecutive bytes from base+3n,
  // packed as {R,G,B,sof,eol,eof}.
  function automatic logic [26:0] model_pixel(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    a0 = base + AW'(3 * n);
    a1 = a0 + AW'(1);
    a2 = a0 + AW'(2);
    return {a2[7:0], a1[7:0], a0[7:0], (n == 0), ((n % W) == W - 1), (n == TOTAL - 1)};
  endfunction

  // Runs one whole frame under the vector's ready pattern and checks every
  // pixel, flag, latency, period and the completion pulse.
  task automatic apply_stimulus(input frame_vec_t v);
    int n;
    int cyc;
    int first_cyc;
    int prev_hs;
    int last_hs;
    int stall_cnt;
    bit done_seen;
    logic [23:0] got0;
    logic [23:0] got2;
    n = 0; cyc = 0; first_cyc = -1; prev_hs = -1; last_hs = -1;
    stall_cnt = 0; done_seen = 0; got0 = '0; got2 = '0;

    @(negedge clk);
    start = 1'b1;
    base_addr = v.base;
    @(negedge clk);
    start = 1'b0;

    while (!done_seen && cyc < 400) begin
      if (n == v.stall_pix && stall_cnt < v.stall_len) begin
        bus.pixel_ready = 1'b0;
        if (bus.input_is_valid) stall_cnt++;
      end else begin
        bus.pixel_ready = ($urandom_range(99) < v.ready_pct);
      end
      if (v.start_noise) begin
        if (last_hs < 0) begin
          start = ($urandom_range(3) == 0);
          base_addr = AW'($urandom);
        end else begin
          start = 1'b0;
        end
      end

      if (bus.input_is_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          check_output("first_latency", cyc, 4);
        end
        if (n >= TOTAL) begin
          check_output("extra_pixel", n, TOTAL - 1);
        end else begin
          check_output("pixel_flags", {5'd0, bus.input_pixel, bus.sof, bus.eol, bus.eof},
                       {5'd0, model_pixel(v.base, n)});
        end
        check_output("no_read_in_out", {31'd0, bus.mem_rd_en}, 0);
        if (n == 0) got0 = bus.input_pixel;
        if (n == 2) got2 = bus.input_pixel;
        if (bus.pixel_ready) begin
          if (prev_hs >= 0 && v.ready_pct == 100 && v.stall_pix < 0)
            check_output("pixel_period", cyc - prev_hs, 5);
          prev_hs = cyc;
          n++;
          if (n == TOTAL) last_hs = cyc;
        end
      end

      check_output("frame_done", {31'd0, frame_done}, {31'd0, (last_hs >= 0 && cyc == last_hs + 1)});
      if (last_hs >= 0 && cyc == last_hs + 1) begin
        done_seen = 1;
        check_output("idle_after_frame", {31'd0, busy}, 0);
        check_output("pixel_count", n, TOTAL);
      end
      cyc++;
      if (!done_seen) @(negedge clk);
    end

    check_output("frame_completed", {31'd0, done_seen}, 1);
    check_output("tbl_first_pixel", {8'd0, got0}, {8'd0, v.exp_first});
    check_output("tbl_third_pixel", {8'd0, got2}, {8'd0, v.exp_third});
    start = 1'b0;
    bus.pixel_ready = 1'b0;
  endtask

  initial begin
    int k;
    int busy_cnt;
    int done_cnt;
    vec_count  = 0;
    miss_count = 0;

    //          base          ready stall len noise first      third
    vecs[0] = '{20'd54,       100,  -1,   0,  0,    24'h383736, 24'h3E3D3C};
    vecs[1] = '{20'd54,       100,   2,  10,  0,    24'h383736, 24'h3E3D3C};
    vecs[2] = '{20'd54,        60,  -1,   0,  1,    24'h383736, 24'h3E3D3C};
    vecs[3] = '{20'hFFFFA,     70,  -1,   0,  0,    24'hFCFBFA, 24'h020100};
    vecs[4] = '{20'd0,         50,  -1,   0,  0,    24'h020100, 24'h080706};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    base_addr = '0;
    bus.pixel_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_ctrl", {5'd0, bus.input_is_valid, bus.mem_rd_en, bus.mem_addr,
                                bus.sof, bus.eol, bus.eof, busy, frame_done}, 0);
    check_output("reset_pixel", {8'd0, bus.input_pixel}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] frame vector %0d, base %0h", i, vecs[i].base);
      apply_stimulus(vecs[i]);
    end

    // Abort during FETCH_G of pixel 5.
    $display("[TB] abort sequence");
    @(negedge clk);
    start = 1'b1; base_addr = 20'd54; bus.pixel_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(bus.mem_rd_en && bus.mem_addr == 20'd70) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_output("abort_reached_fetch_g", {31'd0, (k < 200)}, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_to_idle", {28'd0, busy, bus.input_is_valid, bus.mem_rd_en, frame_done}, 0);
    done_cnt = 0; busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      done_cnt += int'(frame_done);
      busy_cnt += int'(busy);
    end
    check_output("abort_no_done", done_cnt, 0);
    check_output("abort_stays_idle", busy_cnt, 0);
    apply_stimulus(vecs[0]);

    // abort and start together while idle.
    $display("[TB] abort with start sequence");
    @(negedge clk);
    start = 1'b1; abort = 1'b1; base_addr = 20'd54;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    busy_cnt = int'(busy);
    repeat (5) begin
      @(negedge clk);
      busy_cnt += int'(busy);
    end
    check_output("abort_beats_start", busy_cnt, 0);

    // Asynchronous reset between edges in FETCH_R of pixel 2.
    $display("[TB] mid-frame reset sequence");
    @(negedge clk);
    start = 1'b1; base_addr = 20'd54; bus.pixel_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(bus.mem_rd_en && bus.mem_addr == 20'd62) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_output("reset_reached_fetch_r", {31'd0, (k < 200)}, 1);
    #2 rst = 1'b1;
    #1;
    check_output("async_reset_ctrl", {5'd0, bus.input_is_valid, bus.mem_rd_en, bus.mem_addr,
                                      bus.sof, bus.eol, bus.eof, busy, frame_done}, 0);
    check_output("async_reset_pixel", {8'd0, bus.input_pixel}, 0);
    @(negedge clk);
    rst = 1'b0;
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      busy_cnt += int'(busy) + int'(bus.input_is_valid);
    end
    check_output("reset_stays_idle", busy_cnt, 0);
    bus.pixel_ready = 1'b0;
    apply_stimulus(vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
